// File: rtl/fifo_unpacker.sv
// Pops wide words from a show-ahead FIFO read port and replays each one as
// DataWidth/OutWidth narrow beats on a valid/ready stream, LSB slice first.
module fifo_unpacker #(
  parameter int DataWidth = 32,
  parameter int OutWidth  = 8,
  localparam int Ratio    = DataWidth / OutWidth,
  localparam int CntWidth = (Ratio > 1) ? $clog2(Ratio) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifoEmpty,
  input  logic [DataWidth-1:0] fifoReadData,
  output logic                 fifoReadEn,
  input  logic                 flush,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [OutWidth-1:0]  outData,
  output logic                 outLast,
  output logic                 busy
);

  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(Ratio - 1);

  logic [DataWidth-1:0]             wordReg;
  logic                             holdValid;
  logic [CntWidth-1:0]              sliceCnt;
  logic [Ratio-1:0][OutWidth-1:0]   slices;
  logic                             accept;
  logic                             lastAccept;

  // Viewing the held word as an array of slices keeps the beat mux a plain index.
  assign slices     = wordReg;
  assign outValid   = holdValid;
  assign outData    = slices[sliceCnt];
  assign outLast    = holdValid && (sliceCnt == LastCnt);
  assign accept     = outValid && outReady;
  assign lastAccept = accept && outLast;

  // The pop is combinational so the next word loads on the same edge that
  // retires the last slice; gating with rst keeps the FIFO untouched in reset.
  assign fifoReadEn = !rst && !flush && !fifoEmpty && (!holdValid || lastAccept);
  assign busy       = holdValid | fifoReadEn;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordReg   <= '0;
      holdValid <= 1'b0;
      sliceCnt  <= '0;
    end else if (flush) begin
      holdValid <= 1'b0;
      sliceCnt  <= '0;
    end else if (fifoReadEn) begin
      wordReg   <= fifoReadData;
      holdValid <= 1'b1;
      sliceCnt  <= '0;
    end else if (lastAccept) begin
      holdValid <= 1'b0;
      sliceCnt  <= '0;
    end else if (accept) begin
      sliceCnt  <= sliceCnt + CntWidth'(1);
    end
  end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed bench for fifo_unpacker (32->8): a small show-ahead FIFO feeds the
// DUT; each row gives inputs and the expected {valid,last,readEn,busy} nibble + data.
module tb_fifo_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifoEmpty;
  logic [31:0] fifoReadData;
  logic        fifoReadEn;
  logic        flush = 1'b0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [7:0]  outData;
  logic        outLast;
  logic        busy;

  logic [31:0] mem [0:15];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  int          checks = 0;
  int          errors = 0;

  fifo_unpacker #(.DataWidth(32), .OutWidth(8)) dut (
    .clk(clk), .rst(rst), .fifoEmpty(fifoEmpty), .fifoReadData(fifoReadData),
    .fifoReadEn(fifoReadEn), .flush(flush), .outValid(outValid),
    .outReady(outReady), .outData(outData), .outLast(outLast), .busy(busy)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO stand-in: head visible whenever non-empty, popped on readEn.
  assign fifoEmpty    = (wr_ptr == rd_ptr);
  assign fifoReadData = mem[rd_ptr[3:0]];
  always @(posedge clk) if (fifoReadEn) rd_ptr <= rd_ptr + 1;

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr++;
  endtask

  // Table row: {flush, outReady, valid, last, readEn, busy, data[7:0]}.
  // Data is compared only on valid beats; invalid rows expect 00.

  task automatic test_reset();
    logic [11:0] got;
    push(32'hDDCCBBAA);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); outReady = 1'b1; #1;
      checks++;
      got = {outValid, outLast, fifoReadEn, busy, outData};
      if (got !== 12'h000) begin
        errors++;
        $display("FAIL reset[%0d]: got %h required 000", i, got);
      end
      repeat (2) @(posedge clk);
    end
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic test_single();
    logic [13:0] tbl [0:5];
    logic [11:0] got;
    tbl = '{{2'b01,12'h300}, {2'b01,12'h9AA}, {2'b01,12'h9BB},
            {2'b01,12'h9CC}, {2'b01,12'hDDD}, {2'b01,12'h000}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); flush = tbl[i][13]; outReady = tbl[i][12]; #1;
      checks++;
      got = {outValid, outLast, fifoReadEn, busy, outValid ? outData : 8'h00};
      if (got !== tbl[i][11:0]) begin
        errors++;
        $display("FAIL single[%0d]: got %h required %h", i, got, tbl[i][11:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] tbl [0:9];
    logic [11:0] got;
    tbl = '{{2'b01,12'h300}, {2'b01,12'h911}, {2'b01,12'h922}, {2'b01,12'h933},
            {2'b01,12'hF44}, {2'b01,12'h955}, {2'b01,12'h966}, {2'b01,12'h977},
            {2'b01,12'hD88}, {2'b01,12'h000}};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); flush = tbl[i][13]; outReady = tbl[i][12];
      if (i == 0) begin
        push(32'h44332211);
        push(32'h88776655);
      end
      #1;
      checks++;
      got = {outValid, outLast, fifoReadEn, busy, outValid ? outData : 8'h00};
      if (got !== tbl[i][11:0]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h required %h", i, got, tbl[i][11:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [13:0] tbl [0:12];
    logic [11:0] got;
    tbl = '{{2'b01,12'h300}, {2'b01,12'h9AA}, {2'b00,12'h9BB}, {2'b00,12'h9BB},
            {2'b00,12'h9BB}, {2'b01,12'h9BB}, {2'b01,12'h9CC}, {2'b01,12'hFDD},
            {2'b01,12'h90A}, {2'b01,12'h90B}, {2'b01,12'h90C}, {2'b01,12'hD0D},
            {2'b01,12'h000}};
    for (int i = 0; i < 13; i++) begin
      @(negedge clk); flush = tbl[i][13]; outReady = tbl[i][12];
      if (i == 0) begin
        push(32'hDDCCBBAA);
        push(32'h0D0C0B0A);
      end
      #1;
      checks++;
      got = {outValid, outLast, fifoReadEn, busy, outValid ? outData : 8'h00};
      if (got !== tbl[i][11:0]) begin
        errors++;
        $display("FAIL backpressure[%0d]: got %h required %h", i, got, tbl[i][11:0]);
      end
    end
  endtask

  task automatic test_empty();
    logic [11:0] got;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); flush = 1'b0; outReady = 1'b1; #1;
      checks++;
      got = {outValid, outLast, fifoReadEn, busy, outValid ? outData : 8'h00};
      if (got !== 12'h000) begin
        errors++;
        $display("FAIL empty[%0d]: got %h required 000", i, got);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] pre [0:2];
    logic [13:0] post [0:5];
    logic [11:0] got;
    pre  = '{{2'b01,12'h300}, {2'b01,12'h9AA}, {2'b01,12'h9BB}};
    post = '{{2'b01,12'h300}, {2'b01,12'h901}, {2'b01,12'h902},
             {2'b01,12'h903}, {2'b01,12'hD04}, {2'b01,12'h000}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); flush = pre[i][13]; outReady = pre[i][12];
      if (i == 0) push(32'hDDCCBBAA);
      #1;
      checks++;
      got = {outValid, outLast, fifoReadEn, busy, outValid ? outData : 8'h00};
      if (got !== pre[i][11:0]) begin
        errors++;
        $display("FAIL reset_mid_pre[%0d]: got %h required %h", i, got, pre[i][11:0]);
      end
    end
    @(posedge clk); #2 rst = 1'b1; #1;
    checks++;
    got = {outValid, outLast, fifoReadEn, busy, outData};
    if (got !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_async: got %h required 000", got);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); flush = post[i][13]; outReady = post[i][12];
      if (i == 0) push(32'h04030201);
      #1;
      checks++;
      got = {outValid, outLast, fifoReadEn, busy, outValid ? outData : 8'h00};
      if (got !== post[i][11:0]) begin
        errors++;
        $display("FAIL reset_mid_post[%0d]: got %h required %h", i, got, post[i][11:0]);
      end
    end
  endtask

  task automatic test_flush();
    logic [13:0] tbl [0:9];
    logic [11:0] got;
    tbl = '{{2'b01,12'h300}, {2'b01,12'h9AA}, {2'b01,12'h9BB}, {2'b10,12'h9CC},
            {2'b01,12'h300}, {2'b01,12'h90A}, {2'b01,12'h90B}, {2'b01,12'h90C},
            {2'b01,12'hD0D}, {2'b01,12'h000}};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); flush = tbl[i][13]; outReady = tbl[i][12];
      if (i == 0) begin
        push(32'hDDCCBBAA);
        push(32'h0D0C0B0A);
      end
      #1;
      checks++;
      got = {outValid, outLast, fifoReadEn, busy, outValid ? outData : 8'h00};
      if (got !== tbl[i][11:0]) begin
        errors++;
        $display("FAIL flush[%0d]: got %h required %h", i, got, tbl[i][11:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_empty();
    test_reset_mid();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
